// File: rtl/pp_pkg.sv
// Shared types and constants for the PP stream blocks.
package pp_pkg;

  typedef enum logic [1:0] {
    PP_IDLE,
    PP_RUN,
    PP_DONE,
    PP_FAIL
  } pp_sink_state_e;

  // Fibonacci feedback taps 8,6,5,4 expressed as a bit mask over q[7:0].
  localparam logic [7:0] PP_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/pp_stream_sink_if.sv
// Valid/ready byte-stream link between a PP stage (master) and a sink (slave).
// Handshake: a beat transfers on a posedge where ivalid && iready; the master holds
// idata stable while ivalid is high and iready is low, and iready never depends on ivalid.
interface pp_stream_sink_if #(
    parameter int DW = 8
);
    logic          ivalid;
    logic          iready;
    logic [DW-1:0] idata;

    modport master (output ivalid, output idata, input iready);
    modport slave  (input ivalid, input idata, output iready);
endinterface

// File: rtl/pp_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4): synchronous load of a seed, otherwise steps when enabled.
module pp_lfsr8
    import pp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);
    logic [7:0] q_r;
    logic       fb;

    assign fb = ^(q_r & PP_LFSR_TAPS);
    assign q  = q_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= seed;
        end else if (load) begin
            q_r <= seed;
        end else if (step) begin
            q_r <= {q_r[6:0], fb};
        end
    end
endmodule

// File: rtl/pp_stream_sink.sv
// Stream checker: accepts NUM_BEATS beats and compares them to an incrementing sequence.
// Define PP_SINK_STALL_EN to add LFSR-driven pseudo-random backpressure on iready.
module pp_stream_sink
    import pp_pkg::*;
#(
    parameter int           DW        = 8,
    parameter int           NUM_BEATS = 16,
    parameter logic [7:0]   LFSR_SEED = 8'hA5,
    localparam int          CW        = $clog2(NUM_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    exp_base,
    pp_stream_sink_if.slave  s,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CW-1:0]    beat_cnt,
    output logic [DW-1:0]    err_data,
    output pp_sink_state_e   dbg_state
);
    pp_sink_state_e state_q, state_d;
    logic [DW-1:0]  expected_q, expected_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  err_q, err_d;
    logic           stall_ok;
    logic           accept;
    logic           start_ok;

    assign start_ok = (state_q != PP_RUN) && start;

`ifdef PP_SINK_STALL_EN
    logic [7:0] lfsr_q;

    pp_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .seed (LFSR_SEED),
        .step (state_q == PP_RUN),
        .q    (lfsr_q)
    );

    assign stall_ok = lfsr_q[0];
`else
    wire unused_seed = ^LFSR_SEED;

    assign stall_ok = 1'b1;
`endif

    // iready comes from registered state only, so no path from ivalid back to upstream.
    assign s.iready = (state_q == PP_RUN) && stall_ok;
    assign accept   = s.ivalid && s.iready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PP_IDLE;
            expected_q <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            PP_RUN: begin
                if (accept) begin
                    if (s.idata == expected_q) begin
                        expected_d = expected_q + 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                        if (cnt_q == CW'(NUM_BEATS - 1)) begin
                            state_d = PP_DONE;
                        end
                    end else begin
                        err_d   = s.idata;
                        state_d = PP_FAIL;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d    = PP_RUN;
                    expected_d = exp_base;
                    cnt_d      = '0;
                    err_d      = '0;
                end
            end
        endcase
    end

    assign busy      = (state_q == PP_RUN);
    assign done      = (state_q == PP_DONE);
    assign error     = (state_q == PP_FAIL);
    assign beat_cnt  = cnt_q;
    assign err_data  = err_q;
    assign dbg_state = state_q;
endmodule
